// File: rtl/pd_emitter_drive_pkg.sv
// Shared definitions for the emitter drive block.
//   Frame geometry: 2^PBITS clk cycles per frame. A delay code D places a
//   pulse start at phase D << DLY_SHIFT, so the delay quantum is 16 cycles
//   and the phase scale matches the receiver's counter[13:4].
//   state_t    : top-level sequencer states
//   chan_cfg_t : per-channel delay code plus enable bit
package pd_emitter_drive_pkg;

  localparam int NCH       = 5;
  localparam int PBITS     = 14;
  localparam int DBITS     = 10;
  localparam int WBITS     = 8;
  localparam int FBITS     = 16;
  localparam int DLY_SHIFT = PBITS - DBITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DBITS-1:0] delay;
    logic             mask;
  } chan_cfg_t;

endpackage

// File: rtl/pd_emitter_chan.sv
// One emitter channel: start compare, width down-counter and frame-boundary
// truncation, with a registered led output.
//   clk, rst  : clock, synchronous active-high reset
//   phase     : frame phase of the cycle the registered led will be shown on
//   delay     : delay code; pulse starts at phase == delay << DLY_SHIFT
//   width     : pulse width in cycles (0 = channel silent)
//   enable    : channel may drive during that cycle (running and unmasked)
//   boundary  : that cycle is phase 0 of a frame
//   led       : registered emitter drive
module pd_emitter_chan
  import pd_emitter_drive_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PBITS-1:0] phase,
  input  logic [DBITS-1:0] delay,
  input  logic [WBITS-1:0] width,
  input  logic             enable,
  input  logic             boundary,
  output logic             led
);

  logic [WBITS-1:0] remain;
  logic             hit;

  assign hit = (phase == {delay, {DLY_SHIFT{1'b0}}}) && (width != '0);

  // A start at phase 0 is tested before the boundary clear so that a
  // delay-0 pulse is not swallowed by the truncation of the previous one.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      led    <= 1'b0;
      remain <= '0;
    end else if (hit) begin
      led    <= 1'b1;
      remain <= width - WBITS'(1);
    end else if (boundary) begin
      led    <= 1'b0;
      remain <= '0;
    end else if (remain != '0) begin
      led    <= 1'b1;
      remain <= remain - WBITS'(1);
    end else begin
      led    <= 1'b0;
    end
  end

endmodule

// File: rtl/pd_emitter_drive.sv
// Emitter drive sequencer: runs a fixed 2^PBITS-cycle frame and drives NCH
// emitter outputs, each with a programmable start phase and a common width.
//   clk, rst   : clock, synchronous active-high reset
//   en         : run enable; dropping it stops at the next frame boundary
//   start      : one-cycle start strobe, honoured only in IDLE
//   n_frames   : frames per run, 0 = continuous
//   cfg_delays : packed delay codes, channel i at [i*DBITS +: DBITS]
//   cfg_width  : pulse width in cycles, all channels
//   cfg_mask   : per-channel enable
//   cfg_load   : one-cycle strobe capturing cfg_* into the pending copy
//   cfg_ack    : one-cycle pulse on the first cycle the pending copy is active
//   led        : registered emitter drive
//   sync       : phase 0 marker while running
//   phase      : frame phase, aligned with led
//   busy       : running
//   done       : one-cycle pulse after the last frame of a counted run
//   dbg_state  : sequencer state (state_t encoding)
//
// Config handshake: cfg_load is a fire-and-forget strobe with no back
// pressure; every load overwrites the pending copy. The pending copy becomes
// active in IDLE on the first cycle without a fresh load (or at a start),
// and in RUN only at a frame boundary. cfg_ack marks the first cycle the
// new values are in effect; back-to-back loads yield a single ack.
module pd_emitter_drive
  import pd_emitter_drive_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [FBITS-1:0]     n_frames,
  input  logic [NCH*DBITS-1:0] cfg_delays,
  input  logic [WBITS-1:0]     cfg_width,
  input  logic [NCH-1:0]       cfg_mask,
  input  logic                 cfg_load,
  output logic                 cfg_ack,
  output logic [NCH-1:0]       led,
  output logic                 sync,
  output logic [PBITS-1:0]     phase,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  state_t                state, state_nxt;
  logic [PBITS-1:0]      phase_nxt;
  logic [FBITS-1:0]      frame_cnt, frame_cnt_nxt;
  logic                  cont, cont_nxt;
  logic                  wrap, apply, run_nxt, boundary_nxt;

  chan_cfg_t [NCH-1:0]   act_chan, act_chan_nxt, pend_chan, load_chan;
  logic [WBITS-1:0]      act_width, act_width_nxt, pend_width;
  logic                  pend_valid;

  assign wrap = (state == RUN) && (phase == '1);

  always_comb begin
    load_chan = '0;
    for (int i = 0; i < NCH; i++) begin
      load_chan[i].delay = cfg_delays[i*DBITS +: DBITS];
      load_chan[i].mask  = cfg_mask[i];
    end
  end

  // Next-state logic. Pending config is folded into the next active value
  // here so the channels see the new delays on the very first cycle
  // they apply to.
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    cont_nxt      = cont;
    apply         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && en) begin
          state_nxt     = RUN;
          frame_cnt_nxt = n_frames;
          cont_nxt      = (n_frames == '0);
          apply         = pend_valid;
        end else begin
          // A load in flight supersedes the copy about to be applied.
          apply = pend_valid && !cfg_load;
        end
      end
      RUN: begin
        if (wrap) begin
          apply = pend_valid;
          if (!en) begin
            state_nxt = IDLE;
          end else if (!cont && (frame_cnt == FBITS'(1))) begin
            state_nxt = DONE;
          end else if (!cont) begin
            frame_cnt_nxt = frame_cnt - FBITS'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign run_nxt       = (state_nxt == RUN);
  assign phase_nxt     = (run_nxt && (state == RUN)) ? phase + PBITS'(1) : '0;
  assign boundary_nxt  = (phase_nxt == '0);
  assign act_chan_nxt  = apply ? pend_chan  : act_chan;
  assign act_width_nxt = apply ? pend_width : act_width;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      frame_cnt  <= '0;
      cont       <= 1'b0;
      act_chan   <= '0;
      act_width  <= '0;
      pend_chan  <= '0;
      pend_width <= '0;
      pend_valid <= 1'b0;
      cfg_ack    <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      frame_cnt <= frame_cnt_nxt;
      cont      <= cont_nxt;
      act_chan  <= act_chan_nxt;
      act_width <= act_width_nxt;
      cfg_ack   <= apply;
      // A load coinciding with an apply lands after the old copy is taken.
      if (cfg_load) begin
        pend_chan  <= load_chan;
        pend_width <= cfg_width;
        pend_valid <= 1'b1;
      end else if (apply) begin
        pend_valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    pd_emitter_chan u_chan (
      .clk      (clk),
      .rst      (rst),
      .phase    (phase_nxt),
      .delay    (act_chan_nxt[i].delay),
      .width    (act_width_nxt),
      .enable   (run_nxt && act_chan_nxt[i].mask),
      .boundary (boundary_nxt),
      .led      (led[i])
    );
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign sync      = busy && (phase == '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_pd_emitter_drive.sv
`timescale 1ns/1ps
module tb_pd_emitter_drive;
  import pd_emitter_drive_pkg::*;

  localparam int FRAME    = 1 << PBITS;
  localparam int DLY_UNIT = 16;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b1;
  logic                 start = 1'b0;
  logic [FBITS-1:0]     n_frames = '0;
  logic [NCH*DBITS-1:0] cfg_delays = '0;
  logic [WBITS-1:0]     cfg_width = '0;
  logic [NCH-1:0]       cfg_mask = '0;
  logic                 cfg_load = 1'b0;
  logic                 cfg_ack;
  logic [NCH-1:0]       led;
  logic                 sync;
  logic [PBITS-1:0]     phase;
  logic                 busy;
  logic                 done;
  logic [1:0]           dbg_state;

  always #5 clk = ~clk;

  pd_emitter_drive dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .n_frames   (n_frames),
    .cfg_delays (cfg_delays),
    .cfg_width  (cfg_width),
    .cfg_mask   (cfg_mask),
    .cfg_load   (cfg_load),
    .cfg_ack    (cfg_ack),
    .led        (led),
    .sync       (sync),
    .phase      (phase),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the run at the level of "which frame, which phase, which config
  // is live" and derives each led from the pulse window arithmetic.
  state_t         m_st;
  int             m_phase, m_left;
  bit             m_cont, m_ack, pend_v;
  int             act_d[NCH], pend_d[NCH];
  int             act_w, pend_w;
  logic [NCH-1:0] act_m, pend_m;
  logic [31:0]    exp_q[$];

  task automatic model_reset();
    m_st = IDLE; m_phase = 0; m_left = 0; m_cont = 0; m_ack = 0; pend_v = 0;
    act_w = 0; pend_w = 0; act_m = '0; pend_m = '0;
    for (int i = 0; i < NCH; i++) begin
      act_d[i] = 0;
      pend_d[i] = 0;
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [NCH-1:0] l;
    bit             run;
    run = (m_st == RUN);
    for (int i = 0; i < NCH; i++)
      l[i] = run && act_m[i] && (act_w != 0) &&
             (m_phase >= act_d[i] * DLY_UNIT) &&
             (m_phase <= act_d[i] * DLY_UNIT + act_w - 1);
    return {7'b0, l, run && (m_phase == 0), run, m_st == DONE, m_ack,
            2'(m_st), PBITS'(m_phase)};
  endfunction

  task automatic model_step();
    bit     apply;
    state_t nst;
    int     nph;
    apply = 0; nst = m_st; nph = 0;
    if (rst) begin
      model_reset();
    end else begin
      case (m_st)
        IDLE: begin
          if (start && en) begin
            nst = RUN; m_left = int'(n_frames); m_cont = (n_frames == 0); apply = pend_v;
          end else begin
            apply = pend_v && !cfg_load;
          end
        end
        RUN: begin
          if (m_phase == FRAME - 1) begin
            apply = pend_v;
            if (!en) nst = IDLE;
            else if (!m_cont && m_left == 1) nst = DONE;
            else if (!m_cont) m_left--;
          end else begin
            nph = m_phase + 1;
          end
        end
        default: nst = IDLE;
      endcase
      if (nst != RUN) nph = 0;
      if (apply) begin
        act_d = pend_d; act_m = pend_m; act_w = pend_w;
      end
      m_ack = apply;
      if (cfg_load) begin
        for (int i = 0; i < NCH; i++) pend_d[i] = int'(cfg_delays[i*DBITS +: DBITS]);
        pend_m = cfg_mask; pend_w = int'(cfg_width); pend_v = 1;
      end else if (apply) begin
        pend_v = 0;
      end
      m_st = nst; m_phase = nph;
    end
    exp_q.push_back(model_vec());
  endtask

  // ---------------- scoreboard / stats ----------------
  int             led0_cnt, first0, last0, sync_cnt, done_cnt, ack_cnt;
  int             ack_phase, ack_sync, last_busy_phase, done_prev_phase, prev_phase;
  int             ch_cnt[NCH];
  logic [NCH-1:0] sync_led_or;

  task automatic clear_stats();
    led0_cnt = 0; first0 = -1; last0 = -1; sync_cnt = 0; done_cnt = 0; ack_cnt = 0;
    ack_phase = -1; ack_sync = 0; last_busy_phase = -1; done_prev_phase = -1;
    sync_led_or = '0;
    for (int i = 0; i < NCH; i++) ch_cnt[i] = 0;
  endtask

  function automatic logic [31:0] obs_vec();
    return {7'b0, led, sync, busy, done, cfg_ack, dbg_state, phase};
  endfunction

  // One clock: model predicts, DUT clocks, outputs compared at negedge.
  task automatic step();
    logic [31:0] exp_v;
    model_step();
    @(posedge clk);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    check("cycle", obs_vec(), exp_v);
    if (led[0]) begin
      led0_cnt++;
      if (first0 < 0) first0 = int'(phase);
      last0 = int'(phase);
    end
    for (int i = 0; i < NCH; i++) ch_cnt[i] += int'(led[i]);
    if (sync) begin sync_cnt++; sync_led_or |= led; end
    if (done) begin done_cnt++; done_prev_phase = prev_phase; end
    if (cfg_ack) begin ack_cnt++; ack_phase = int'(phase); ack_sync = int'(sync); end
    if (busy) last_busy_phase = int'(phase);
    prev_phase = int'(phase);
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [NCH*DBITS-1:0] rand_delays();
    logic [NCH*DBITS-1:0] d;
    for (int i = 0; i < NCH; i++) d[i*DBITS +: DBITS] = DBITS'($urandom_range(0, 1023));
    return d;
  endfunction

  task automatic load_cfg(input logic [NCH*DBITS-1:0] d, input logic [NCH-1:0] m, input int w);
    cfg_delays = d; cfg_mask = m; cfg_width = WBITS'(w); cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic start_run(input int nf);
    n_frames = FBITS'(nf); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (dbg_state == 2'd0) begin ok = 1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic run_to_phase(input string tag, input int p, input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (busy && int'(phase) == p) begin ok = 1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [NCH*DBITS-1:0] dl;
    int                   w2;
    model_reset();
    clear_stats();

    // Reset
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("reset_outputs", obs_vec(), 32'd0);

    // 1: single frame, D0=5 W=20, only channel 0
    clear_stats();
    dl = rand_delays(); dl[DBITS-1:0] = 10'd5;
    load_cfg(dl, 5'b00001, 20);
    step();
    check("s1_ack", 32'(ack_cnt), 32'd1);
    clear_stats();
    start_run(1);
    run_until_idle("s1_end", FRAME + 16);
    check("s1_led0_cnt", 32'(led0_cnt), 32'd20);
    check("s1_first", 32'(first0), 32'd80);
    check("s1_last", 32'(last0), 32'd99);
    check("s1_sync", 32'(sync_cnt), 32'd1);
    check("s1_done", 32'(done_cnt), 32'd1);
    check("s1_done_at", 32'(done_prev_phase), 32'd16383);
    step();
    check("s1_busy_after", {31'b0, busy}, 32'd0);

    // 2: D=1023 W=255 all channels, two frames -> truncated 16-cycle pulses
    for (int i = 0; i < NCH; i++) dl[i*DBITS +: DBITS] = 10'd1023;
    load_cfg(dl, 5'b11111, 255);
    step();
    clear_stats();
    start_run(2);
    run_until_idle("s2_end", 2 * FRAME + 16);
    for (int i = 0; i < NCH; i++) check($sformatf("s2_ch%0d_cnt", i), 32'(ch_cnt[i]), 32'd32);
    check("s2_first", 32'(first0), 32'd16368);
    check("s2_last", 32'(last0), 32'd16383);
    check("s2_led_at_sync", 32'(sync_led_or), 32'd0);
    check("s2_sync", 32'(sync_cnt), 32'd2);
    check("s2_done", 32'(done_cnt), 32'd1);

    // 3: continuous, D0=0 W=1, random other channels; reconfigure mid-frame
    dl = rand_delays(); dl[DBITS-1:0] = 10'd0;
    load_cfg(dl, 5'($urandom_range(0, 31)) | 5'b00001, 1);
    step();
    clear_stats();
    start_run(0);
    start = 1'b1;                       // stray start while running
    step();
    start = 1'b0;
    run_to_phase("s3_reach5000", 5000, FRAME);
    check("s3_first0", 32'(first0), 32'd0);
    check("s3_led0_cnt", 32'(led0_cnt), 32'd1);
    dl = rand_delays(); dl[DBITS-1:0] = 10'd10;
    w2 = $urandom_range(1, 255);
    load_cfg(dl, 5'($urandom_range(0, 31)) | 5'b00001, w2);
    clear_stats();
    run_to_phase("s3_reach3000", 3000, FRAME + 16);
    check("s3_ack_cnt", 32'(ack_cnt), 32'd1);
    check("s3_ack_phase", 32'(ack_phase), 32'd0);
    check("s3_ack_sync", 32'(ack_sync), 32'd1);
    check("s3_first0_new", 32'(first0), 32'd160);
    check("s3_led0_cnt_new", 32'(led0_cnt), 32'(w2));

    // 3b: drop en at phase 3000 -> finish frame, no done
    en = 1'b0;
    clear_stats();
    run_until_idle("s3_stop", FRAME + 16);
    check("s3_last_busy", 32'(last_busy_phase), 32'd16383);
    check("s3_no_done", 32'(done_cnt), 32'd0);
    check("s3_idle_out", {7'b0, led, phase}, 32'd0);
    en = 1'b1;

    // 4: two loads back to back in IDLE -> one ack, second config live
    clear_stats();
    dl = rand_delays(); dl[DBITS-1:0] = 10'd3;
    load_cfg(dl, 5'b00001, 20);
    dl[DBITS-1:0] = 10'd5;
    load_cfg(dl, 5'b00001, 20);
    repeat (3) step();
    check("s4_ack_cnt", 32'(ack_cnt), 32'd1);
    clear_stats();
    start_run(1);
    run_to_phase("s4_reach85", 85, 200);
    for (int i = 0; i < NCH; i++) dl[i*DBITS +: DBITS] = '0;
    load_cfg(dl, 5'b11111, 50);          // left pending, then discarded by rst
    run_to_phase("s4_reach90", 90, 200);
    check("s4_first0", 32'(first0), 32'd80);
    check("s4_led0_on", {31'b0, led[0]}, 32'd1);

    // 5: reset mid-pulse; restart without a load emits nothing
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("s5_rst_out", {7'b0, led, sync, busy, done, cfg_ack, dbg_state, phase}, 32'd0);
    clear_stats();
    start_run(1);
    repeat (1000) step();
    check("s5_ack", 32'(ack_cnt), 32'd0);
    check("s5_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < NCH; i++) check($sformatf("s5_ch%0d_quiet", i), 32'(ch_cnt[i]), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pd_emitter_drive.md
Name: pd_emitter_drive

Overview:
- Emitter-side partner of the photodiode delay measurement path: drives up to five LED/emitter outputs with programmable per-channel phase inside a fixed 2^PBITS-cycle frame.
- Frame phase and delay quantisation (16-cycle steps, 10-bit delay) match the receiver's counter[13:4] phase scale, so a known optical loopback delay can be injected and read back.
- Sits between the PS register bank (config plus start/stop) and the emitter pins.

Parameters:
- NCH, 5, number of emitter channels
- PBITS, 14, log2 of frame length in clk cycles
- DBITS, 10, delay field width; delay unit = 2^(PBITS-DBITS) = 16 cycles
- WBITS, 8, pulse width field in clk cycles
- FBITS, 16, frame-count width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  run enable; deassert requests a stop at the next frame boundary
- start  in  1  one-cycle start strobe, honoured only in IDLE
- n_frames  in  FBITS  frames to emit; 0 = continuous
- cfg_delays  in  NCH*DBITS  packed delays, channel i in bits [i*DBITS +: DBITS]
- cfg_width  in  WBITS  pulse width in cycles, common to all channels
- cfg_mask  in  NCH  per-channel enable
- cfg_load  in  1  one-cycle strobe capturing cfg_* into a pending register
- cfg_ack  out  1  one-cycle pulse when pending config becomes active
- led  out  NCH  emitter drive, registered
- sync  out  1  high on the cycle where phase==0 in RUN
- phase  out  PBITS  frame counter, registered and aligned with led
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset values: all outputs 0; state IDLE; active and pending config zero (all channels off); pending flag clear.
- States:
  - IDLE -> RUN on start && en. Same cycle: phase loads 0, pending applied if set, frame_cnt loads n_frames.
  - RUN: phase increments by 1 each cycle and wraps from 2^PBITS-1 to 0 (frame boundary).
    - At a boundary, if !en -> IDLE.
    - Else if n_frames!=0 and frame_cnt==1 -> DONE.
    - Else stay in RUN and decrement frame_cnt (no decrement when n_frames==0).
  - DONE -> IDLE after one cycle; done=1 during that cycle.
- Pulse rule: led[i]=1 exactly on cycles where busy, mask[i], W!=0, and D_i*16 <= phase <= D_i*16+W-1. Implement with per-channel width down-counters.
- Wrap truncation: a pulse whose end would exceed 2^PBITS-1 is cut at the frame boundary and never spills into the next frame. A delay-0 pulse in the new frame starts normally at phase 0 (new start beats the truncation clear).
- Pulse width: W=1 gives a one-cycle pulse. W=255 with D=1023 (start phase 16368) runs to phase 16383, 16 cycles, then truncates.
- Config handshake:
  - cfg_load in any state copies cfg_* to pending and sets the flag; a second load before apply overwrites pending, and only one ack follows.
  - In IDLE, pending applies on the next cycle.
  - In RUN, pending applies only at a frame boundary, so delays never change mid-frame.
  - cfg_ack pulses on the apply cycle.
  - cfg_load on the same cycle as apply: the apply uses the old pending, and the new value stays pending.
- Leaving RUN for any reason forces led=0, busy=0, phase=0 on the next cycle.
- start outside IDLE is ignored.
- rst mid-frame: all outputs 0 on the next cycle, and pending config is discarded.

Decomposition:
- Shared package holds:
  - constants NCH, PBITS, DBITS, WBITS, DLY_SHIFT=PBITS-DBITS
  - state enum {IDLE, RUN, DONE}
  - packed channel-config struct {delay, mask bit}
- Sub-module pd_emitter_chan, instantiated NCH times:
  - inputs: phase, delay, width, enable, boundary
  - owns the width down-counter, match compare, truncation
  - outputs one led bit

Test Plan:
- Reset, load D0=5, W=20, mask=00001, start with n_frames=1 -> led[0] high for phase 80..99 only, sync once, done pulse at the cycle after phase 16383, busy low after.
- D=1023, W=255, all channels, n_frames=2 -> each pulse 16 cycles (phase 16368..16383), no high at phase 0 of frame 2, frame 2 matches frame 1.
- Continuous run D0=0, W=1; cfg_load at phase 5000 with D0=10 -> cfg_ack at next phase-0 cycle; that frame pulses at phase 160, not 0; no mid-frame change.
- Two cfg_load strobes in IDLE on consecutive cycles -> single cfg_ack; active config equals the second load.
- Drop en at phase 3000 in continuous mode -> RUN continues to 16383, then IDLE with led=0, and done never pulses.
- Assert rst at phase 90 during an active pulse -> led, busy, phase, and cfg_ack 0 next cycle; a subsequent start without cfg_load emits no pulses (config zeroed).
